seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS hex seven-segment digits; one shared segment bus.

---
 rtl/seven_seg_scan_driver.sv | 195 +++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed driver for NUM_DIGITS hex seven-segment digits that share
// one segment bus. A refresh prescaler advances a digit scan counter once per
// REFRESH_DIV clocks. New display values are captured into a shadow buffer and
// promoted to the display register only when the scan wraps back to digit 0,
// so a frame never mixes old and new digits.
//
// Handshake: load_i is a single-cycle strobe with no back-pressure. Every
// cycle where load_i=1 overwrites the shadow buffer, so the last load before
// a wrap is the one that gets displayed. pending_o reports that the shadow
// buffer holds data the display has not yet taken.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_SUPPRESS_EN - blank digits above the most-significant non-zero
//                              nibble; digit 0 is never suppressed.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous, active-high reset
//   value_i        nibble k = value_i[4k+3:4k] drives digit k (k=0 rightmost)
//   load_i         strobe: capture value_i and blank_mask_i into the shadow
//   blank_mask_i   bit k=1 shows digit k with all segments off
//   seg_o          {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   dig_en_o       one-hot digit select, polarity set by ACTIVE_LOW
//   pending_o      shadow holds data not yet displayed
//   frame_done_o   one-cycle pulse after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    pending_o,
    output logic                    frame_done_o
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int BUF_W = 5 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that convert active-high patterns to pin polarity; they are
    // also the "all off" pin values.
    localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

    // Buffers hold {blank_mask, value}.
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUF_W-1:0]      disp_q, disp_d;
    logic [BUF_W-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

    logic                  tick;
    logic                  wrap;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] disp_mask;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] dig_onehot;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick = (div_cnt_q == DIV_MAX);
    // The wrap tick is the tick taken on the last digit; buffer swaps happen here.
    assign wrap = tick && (idx_q == IDX_MAX);

    assign disp_val  = disp_q[VAL_W-1:0];
    assign disp_mask = disp_q[BUF_W-1:VAL_W];

    // Digit selection and decode of the currently scanned digit.
    always_comb begin
`ifdef LEADING_ZERO_SUPPRESS_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        lz_blank   = '0;
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        dig_onehot = '0;
`ifdef LEADING_ZERO_SUPPRESS_EN
        // Walk down from the top digit: a digit is suppressed while it and
        // every digit above it are zero. Digit 0 is left out on purpose.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero & (disp_val[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero;
        end
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib       = disp_val[4*k +: 4];
                cur_blank     = disp_mask[k] | lz_blank[k];
                dig_onehot[k] = 1'b1;
            end
        end
        // Blanked digits keep their enable so scan timing does not change.
        seg_d    = (cur_blank ? 7'h00 : hex_decode(cur_nib)) ^ SEG_POL;
        dig_en_d = dig_onehot ^ DIG_POL;
    end

    // Prescaler, scan counter and double buffer next state.
    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = wrap;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end

        if (load_i) begin
            shadow_d = {blank_mask_i, value_i};
        end

        if (wrap && load_i) begin
            // A load coinciding with the wrap goes straight to the display.
            disp_d    = {blank_mask_i, value_i};
            pending_d = 1'b0;
        end else if (wrap && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (load_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_POL;
            dig_en_q     <= DIG_POL;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
        end
    end

    assign seg_o        = seg_q;
    assign dig_en_o     = dig_en_q;
    assign pending_o    = pending_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Bench for seven_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW=1: one digit slot is 4 clocks, one frame is 16 clocks, and the
// wrap ticks fall on edges 16, 32, ... counted from reset release.
// Expected {dig_en, seg} words are queued when a load is driven and popped
// one per clock as the display produces them.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    logic            clk;
    logic            rst;
    logic [4*ND-1:0] value;
    logic            load;
    logic [ND-1:0]   blank_mask;
    logic [6:0]      seg;
    logic [ND-1:0]   dig_en;
    logic            pending;
    logic            frame_done;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    logic pend_m = 1'b0;
    logic [15:0] disp_val  = 16'h0;
    logic [3:0]  disp_mask = 4'h0;

    logic [10:0] exp_q[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .value_i     (value),
        .load_i      (load),
        .blank_mask_i(blank_mask),
        .seg_o       (seg),
        .dig_en_o    (dig_en),
        .pending_o   (pending),
        .frame_done_o(frame_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Pin-level {dig_en, seg} for frame position pos (0..15) of a value.
    function automatic logic [10:0] exp_word(input logic [15:0] v, input logic [3:0] m,
                                             input int pos);
        int d;
        logic [3:0] nib;
        logic blank;
        logic [6:0] s;
        logic [3:0] de;
        d     = pos / DIV;
        nib   = v[4*d +: 4];
        blank = m[d];
`ifdef LEADING_ZERO_SUPPRESS_EN
        if (d != 0 && (v >> (4*d)) == 16'h0) blank = 1'b1;
`endif
        s  = blank ? 7'h00 : hex7(nib);
        de = 4'b0001 << d;
        return {~de, ~s};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock with scoreboard pop plus frame_done/pending checks.
    task automatic step_chk();
        logic [10:0] e;
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n % FRAME == 0) pend_m = 1'b0;
        else if (load)           pend_m = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan", 32'({dig_en, seg}), 32'(e));
        end
        check("frame_done", 32'(frame_done), 32'(edge_n % FRAME == 0));
        check("pending", 32'(pending), 32'(pend_m));
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] m, input int from_pos);
        for (int p = from_pos; p < FRAME; p++) exp_q.push_back(exp_word(v, m, p));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_word(disp_val, disp_mask, edge_n % FRAME));
            step_chk();
        end
    endtask

    // n loads on consecutive cycles; only the last carries v/m, earlier ones
    // carry junk that must never be displayed.
    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input int n);
        push_frame(disp_val, disp_mask, edge_n % FRAME);
        push_frame(v, m, 0);
        for (int i = 0; i < n; i++) begin
            value      = (i == n - 1) ? v : 16'hEEEE;
            blank_mask = (i == n - 1) ? m : 4'hF;
            load       = 1'b1;
            step_chk();
        end
        load = 1'b0;
        while (exp_q.size() > 0) step_chk();
        disp_val  = v;
        disp_mask = m;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value      = '0;
        blank_mask = '0;

        // Reset holds all-off outputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dig", 32'(dig_en), 32'hF);
            check("rst_pending", 32'(pending), 32'h0);
            check("rst_frame_done", 32'(frame_done), 32'h0);
        end
        rst    = 1'b0;
        edge_n = 0;

        // Scan of 1234, loaded during the first (all-zero) frame.
        do_load(16'h1234, 4'h0, 1);

        // Tear-free update: load while digit 2 is being shown.
        idle(9);
        do_load(16'hABCD, 4'h0, 1);

        // Load exactly on the wrap tick: bypass, pending never rises.
        idle(FRAME - 1);
        do_load(16'h00F0, 4'h0, 1);

        // Blanking, back-to-back loads, leading zeros.
        do_load(16'h5678, 4'b0010, 1);
        do_load(16'h9E0F, 4'h0, 3);
        do_load(16'h0007, 4'h0, 1);
        do_load(16'h0000, 4'h0, 1);
        do_load(16'h3C1B, 4'b1001, 1);

        // Mid-frame reset with a load pending at digit 2.
        idle(9);
        exp_q.push_back(exp_word(disp_val, disp_mask, edge_n % FRAME));
        value = 16'h4321;
        load  = 1'b1;
        step_chk();
        load = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dig", 32'(dig_en), 32'hF);
        check("midrst_pending", 32'(pending), 32'h0);
        check("midrst_frame_done", 32'(frame_done), 32'h0);
        rst       = 1'b0;
        edge_n    = 0;
        pend_m    = 1'b0;
        disp_val  = 16'h0;
        disp_mask = 4'h0;
        // Two frames of zero: the discarded load must not reappear at the wrap.
        push_frame(16'h0, 4'h0, 0);
        push_frame(16'h0, 4'h0, 0);
        while (exp_q.size() > 0) step_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
